// File: rtl/rv32i_types.sv
// Shared types and sizing constants for the instruction-memory responder.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_FILL = 2'd2,
    RESP      = 2'd3
  } imem_state_t;

  localparam int LINE_BYTES = 32;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = 4;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int TAG_W      = 23;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
  } imem_req_t;

endpackage

// File: rtl/imem_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational
// read port and one full-line write port used only by refill.
module imem_line_array
  import rv32i_types::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TW    = 32 - 5 - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TW-1:0]     o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TW-1:0]     i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_line
);

  logic [SETS-1:0]   r_valid;
  logic [TW-1:0]     r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];

  // Only the valid bits need reset; stale tag/data behind a clear valid is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Read-only direct-mapped instruction cache answering fetch requests and
// refilling 32-byte lines from burst memory as four 64-bit beats.
module imem_responder
  import rv32i_types::*;
#(
  parameter int SETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  input  logic        imem_trigger,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid,
  output imem_state_t dbg_state
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TW    = 32 - 5 - IDX_W;

  // Handshakes: a fetch request is taken only when imem_trigger=1 with a
  // nonzero mask while IDLE; imem_resp is a one-cycle pulse. bmem_read is held
  // with a stable bmem_addr until bmem_ready=1, after which every cycle with
  // bmem_rvalid=1 delivers the next beat; rvalid outside the fill is ignored.

  imem_state_t       r_state, w_state_n;
  imem_req_t         r_req;
  logic [1:0]        r_cnt;
  logic [BEAT_W-1:0] r_buf [BEATS-1];

  logic              w_accept, w_hit, w_fill_last;
  logic [31:0]       w_look_addr;
  logic              w_rd_valid;
  logic [TW-1:0]     w_rd_tag;
  logic [LINE_W-1:0] w_rd_line;
  logic              w_unused_ok;

  assign w_accept    = (r_state == IDLE) && imem_trigger && (imem_rmask != 4'b0);
  // In IDLE the lookup runs on the live inputs so a hit can answer next cycle.
  assign w_look_addr = (r_state == IDLE) ? imem_addr : r_req.addr;
  assign w_hit       = w_rd_valid && (w_rd_tag == w_look_addr[31:5+IDX_W]);
  assign w_fill_last = (r_state == MISS_FILL) && bmem_rvalid && (r_cnt == 2'd3);
  assign dbg_state   = r_state;
  assign w_unused_ok = ^{r_req.addr[1:0], r_req.rmask};

  imem_line_array #(
    .SETS (SETS)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_look_addr[5+IDX_W-1:5]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (w_fill_last),
    .i_wr_idx   (r_req.addr[5+IDX_W-1:5]),
    .i_wr_tag   (r_req.addr[31:5+IDX_W]),
    .i_wr_line  ({bmem_rdata, r_buf[2], r_buf[1], r_buf[0]})
  );

  always_comb begin
    w_state_n  = r_state;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    bmem_read  = 1'b0;
    bmem_addr  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_n = w_hit ? RESP : MISS_REQ;
      end
      MISS_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = {r_req.addr[31:5], 5'b0};
        if (bmem_ready) w_state_n = MISS_FILL;
      end
      MISS_FILL: begin
        if (w_fill_last) w_state_n = RESP;
      end
      RESP: begin
        imem_resp  = 1'b1;
        imem_rdata = w_rd_line[{r_req.addr[4:2], 5'b0} +: 32];
        w_state_n  = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) r_req <= '{addr: imem_addr, rmask: imem_rmask};
      if (r_state == MISS_REQ && bmem_ready) begin
        r_cnt <= '0;
      end else if (r_state == MISS_FILL && bmem_rvalid) begin
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  // The last beat goes straight into the array, so only beats 0..2 are buffered.
  always_ff @(posedge clk) begin
    if (r_state == MISS_FILL && bmem_rvalid && r_cnt != 2'd3) begin
      r_buf[r_cnt] <= bmem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder: a byte-addressed memory function plus a
// set->line-address cache model predict hit/miss, refill address and rdata.
module tb_imem_responder;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_trigger;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  imem_state_t dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        m_valid [16];
  logic [26:0] m_line  [16];

  always #5 clk = ~clk;

  imem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rmask   (imem_rmask),
    .imem_trigger (imem_trigger),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .bmem_addr    (bmem_addr),
    .bmem_read    (bmem_read),
    .bmem_ready   (bmem_ready),
    .bmem_rdata   (bmem_rdata),
    .bmem_rvalid  (bmem_rvalid),
    .dbg_state    (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing memory contents as a function of word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1eceb000) return 32'h00000093;
    if (a == 32'h1eceb004) return 32'h00000013;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [63:0] mem_beat(input logic [26:0] line, input int k);
    logic [31:0] base;
    base = {line, 5'b0} + 32'(8 * k);
    return {mem_word(base + 32'd4), mem_word(base)};
  endfunction

  // One fetch request, acting as the burst memory when a miss is predicted.
  task automatic do_req(input logic [31:0] addr, input int ready_wait, input int max_gap,
                        input bit poke);
    logic [26:0] line;
    int          idx;
    bit          exp_hit;
    int          extra;
    int          unsteady;
    int          gaps;
    logic [31:0] w;
    line    = addr[31:5];
    idx     = int'(addr[8:5]);
    exp_hit = m_valid[idx] && (m_line[idx] == line);
    extra   = 0;
    unsteady = 0;
    exp_q.push_back(mem_word({addr[31:2], 2'b00}));

    @(negedge clk);
    imem_addr    = addr;
    imem_rmask   = 4'($urandom_range(1, 15));
    imem_trigger = 1'b1;
    @(negedge clk);
    imem_trigger = 1'b0;
    imem_rmask   = 4'h0;
    imem_addr    = $urandom;

    if (exp_hit) begin
      check_eq("hit_resp", imem_resp, 1);
      check_eq("hit_no_read", bmem_read, 0);
      w = exp_q.pop_front();
      check_eq("hit_rdata", imem_rdata, w);
    end else begin
      check_eq("miss_no_early_resp", imem_resp, 0);
      check_eq("miss_read", bmem_read, 1);
      check_eq("miss_addr", bmem_addr, {line, 5'b0});
      for (int c = 0; c < ready_wait; c++) begin
        bmem_rvalid = poke;
        bmem_rdata  = {$urandom, $urandom};
        @(negedge clk);
        if (bmem_read !== 1'b1 || bmem_addr !== {line, 5'b0} || imem_resp !== 1'b0) unsteady++;
      end
      bmem_rvalid = 1'b0;
      bmem_ready  = 1'b1;
      @(negedge clk);
      bmem_ready = 1'b0;
      check_eq("read_steady", unsteady, 0);
      for (int k = 0; k < 4; k++) begin
        gaps = $urandom_range(0, max_gap);
        for (int g = 0; g < gaps; g++) begin
          if (poke && g == 0) begin
            imem_trigger = 1'b1;
            imem_rmask   = 4'hF;
          end
          @(negedge clk);
          imem_trigger = 1'b0;
          imem_rmask   = 4'h0;
          if (imem_resp !== 1'b0) extra++;
        end
        bmem_rdata  = mem_beat(line, k);
        bmem_rvalid = 1'b1;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_rdata  = {$urandom, $urandom};
        if (k < 3 && imem_resp !== 1'b0) extra++;
      end
      check_eq("fill_resp", imem_resp, 1);
      w = exp_q.pop_front();
      check_eq("fill_rdata", imem_rdata, w);
      check_eq("fill_no_extra_resp", extra, 0);
      m_valid[idx] = 1'b1;
      m_line[idx]  = line;
    end

    // A trigger presented during the response cycle must be dropped.
    if (poke) begin
      imem_trigger = 1'b1;
      imem_rmask   = 4'hF;
    end
    @(negedge clk);
    imem_trigger = 1'b0;
    imem_rmask   = 4'h0;
    check_eq("resp_one_cycle", imem_resp, 0);
    if (poke) check_eq("resp_trig_ignored", dbg_state, IDLE);
  endtask

  initial begin
    logic [22:0] tag_pool [3];
    logic [31:0] a;
    tag_pool[0] = 23'h0F675;
    tag_pool[1] = 23'h0F676;
    tag_pool[2] = 23'h12345;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    rst          = 1'b1;
    imem_addr    = '0;
    imem_rmask   = '0;
    imem_trigger = 1'b0;
    bmem_ready   = 1'b0;
    bmem_rdata   = '0;
    bmem_rvalid  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_resp", imem_resp, 0);
    check_eq("rst_rdata", imem_rdata, 0);
    check_eq("rst_read", bmem_read, 0);
    check_eq("rst_baddr", bmem_addr, 0);

    do_req(32'h1eceb000, 2, 0, 1'b0);
    do_req(32'h1eceb004, 0, 0, 1'b0);

    // rmask=0 on a cached address must not start anything.
    @(negedge clk);
    imem_addr    = 32'h1eceb000;
    imem_rmask   = 4'h0;
    imem_trigger = 1'b1;
    @(negedge clk);
    imem_trigger = 1'b0;
    check_eq("mask0_resp", imem_resp, 0);
    check_eq("mask0_state", dbg_state, IDLE);
    check_eq("mask0_read", bmem_read, 0);

    do_req(32'h1eceb200, 1, 0, 1'b0);
    do_req(32'h1eceb000, 0, 0, 1'b0);
    do_req(32'h1eceb41c, 5, 3, 1'b1);

    // Reset in the middle of a refill: nothing may be installed.
    @(negedge clk);
    imem_addr    = 32'h00000124;
    imem_rmask   = 4'h3;
    imem_trigger = 1'b1;
    @(negedge clk);
    imem_trigger = 1'b0;
    check_eq("abort_read", bmem_read, 1);
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem_rdata  = mem_beat(27'(32'h00000124 >> 5), k);
      bmem_rvalid = 1'b1;
      @(negedge clk);
      bmem_rvalid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_state", dbg_state, IDLE);
    check_eq("abort_resp", imem_resp, 0);
    check_eq("abort_read_drop", bmem_read, 0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    do_req(32'h00000124, 1, 1, 1'b0);
    do_req(32'h1eceb004, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      a = {tag_pool[$urandom_range(0, 2)], 4'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_req(a, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
